// File: rtl/neuron_mac_pkg.sv
// neuron_pkg: shared definitions for the neuron_mac slice.
//   - neuron_state_e : FSM states ACCUM -> DRAIN -> ROUND -> HOLD -> ACCUM
//   - DEF_* : default N_INPUTS / DATA_W / ACC_W / SHIFT values
//   - OUT_W : width of the pre-activation result and of the bias
//   - cntWidth() : beat counter width for a given vector length
package neuron_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } neuron_state_e;

    localparam int DEF_N_INPUTS = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ACC_W    = 48;
    localparam int DEF_SHIFT    = 8;
    localparam int OUT_W        = 32;

    // A one-beat vector still needs a one-bit counter to keep the vector legal.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: beat stream in, result handshake out, plus bias and len_err.
//   master : the producer/consumer side (drives beats, bias, out_ready)
//   slave  : the neuron_mac side (drives in_ready, out_valid, out_x, len_err)
// Signals:
//   in_valid/in_ready/in_data/in_weight/in_last : input beat handshake
//   bias      : signed bias, sampled while the neuron is in ROUND
//   out_valid/out_ready/out_x : result handshake, out_x stable while valid
//   len_err   : one-cycle pulse on a vector-length violation
interface neuron_mac_if import neuron_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] in_weight;
    logic                     in_last;
    logic signed [OUT_W-1:0]  bias;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_x;
    logic                     len_err;

    modport master (
        output in_valid, in_data, in_weight, in_last, bias, out_ready,
        input  in_ready, out_valid, out_x, len_err
    );

    modport slave (
        input  in_valid, in_data, in_weight, in_last, bias, out_ready,
        output in_ready, out_valid, out_x, len_err
    );

endinterface

// File: rtl/neuron_mac_round_sat.sv
// mac_round_sat: combinational bias add, arithmetic right shift and
// saturate-or-wrap down to OUT_W bits.
//   acc_i  : signed accumulator, ACC_W bits
//   bias_i : signed bias, OUT_W bits, scaled up by SHIFT before the add
//   x_o    : signed OUT_W-bit result
// Build option NEURON_MAC_SAT_EN: clamp to the OUT_W signed range instead of
// keeping the low OUT_W bits.
module mac_round_sat import neuron_pkg::*; #(
    parameter int ACC_W = DEF_ACC_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [OUT_W-1:0] bias_i,
    output logic signed [OUT_W-1:0] x_o
);

    // One guard bit above the accumulator so the bias add cannot overflow.
    logic signed [ACC_W:0] accExt;
    logic signed [ACC_W:0] biasExt;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;

    assign accExt  = {acc_i[ACC_W-1], acc_i};
    assign biasExt = {{(ACC_W + 1 - OUT_W){bias_i[OUT_W-1]}}, bias_i};
    assign sum     = accExt + (biasExt <<< SHIFT);
    // Arithmetic shift floors toward minus infinity (-1 >>> 8 == -1).
    assign shifted = sum >>> SHIFT;

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Clamp anything outside the signed OUT_W range onto its nearest bound.
    always_comb begin
        x_o = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            x_o = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            x_o = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    // Two's-complement wrap: the bits above OUT_W are simply dropped.
    logic unusedHighBits;
    assign unusedHighBits = ^shifted[ACC_W:OUT_W];

    always_comb begin
        x_o = shifted[OUT_W-1:0];
    end
`endif

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate neuron producing the signed
// pre-activation value for the downstream sigmoid stage.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : neuron_mac_if.slave (beat stream, bias, result handshake, len_err)
// Flow: each accepted beat registers data*weight; the registered product is
// added into the accumulator one cycle later. After the terminating beat the
// FSM drains the final product, rounds (bias add, shift, saturate/wrap) and
// holds the result until the consumer accepts it.
// Build option NEURON_MAC_SAT_EN: saturate the result instead of wrapping.
module neuron_mac import neuron_pkg::*; #(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int SHIFT    = DEF_SHIFT
) (
    input  logic         clk,
    input  logic         reset,
    neuron_mac_if.slave  bus
);

    localparam int CNT_W  = cntWidth(N_INPUTS);
    localparam int PROD_W = 2 * DATA_W;

    neuron_state_e            state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [PROD_W-1:0] prod_d;
    logic                     prodValid_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [OUT_W-1:0]  outX_q;
    logic signed [OUT_W-1:0]  roundX_d;
    logic                     outValid_q;
    logic                     lenErr_q;

    logic                     inReady;
    logic                     accept;
    logic                     isNth;
    logic                     endOfVector;
    logic signed [DATA_W-1:0] dataS;
    logic signed [DATA_W-1:0] weightS;

    assign dataS   = bus.in_data;
    assign weightS = bus.in_weight;

    // Beat acceptance, product and accumulator next values. Ready is held low
    // during reset so nothing upstream mistakes a reset cycle for a transfer.
    always_comb begin
        inReady     = (state_q == ACCUM) && !reset;
        accept      = bus.in_valid && inReady;
        isNth       = (cnt_q == CNT_W'(N_INPUTS - 1));
        endOfVector = bus.in_last || isNth;
        cnt_d       = cnt_q + CNT_W'(1);
        prod_d      = PROD_W'(dataS) * PROD_W'(weightS);
        acc_d       = acc_q;
        if (prodValid_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
    end

    mac_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_round (
        .acc_i  (acc_q),
        .bias_i (bus.bias),
        .x_o    (roundX_d)
    );

    // Single FSM with registered outputs. The accumulator absorbs the
    // pending product every cycle regardless of state, which is what lets
    // DRAIN fold in the last product without special handling. A vector
    // ends on in_last or on the N-th beat; len_err flags the case where
    // those two do not coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            prod_q      <= '0;
            prodValid_q <= 1'b0;
            acc_q       <= '0;
            outX_q      <= '0;
            outValid_q  <= 1'b0;
            lenErr_q    <= 1'b0;
        end else begin
            lenErr_q    <= 1'b0;
            prodValid_q <= 1'b0;
            acc_q       <= acc_d;
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        prod_q      <= prod_d;
                        prodValid_q <= 1'b1;
                        if (endOfVector) begin
                            cnt_q    <= '0;
                            lenErr_q <= bus.in_last ^ isNth;
                            state_q  <= DRAIN;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                DRAIN: begin
                    state_q <= ROUND;
                end
                ROUND: begin
                    outX_q     <= roundX_d;
                    outValid_q <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.out_x     = outX_q;
    assign bus.len_err   = lenErr_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: self-checking bench for neuron_mac.
// Two DUTs share one stimulus stream: dutA with SHIFT=8 and dutB with
// SHIFT=0, both with N_INPUTS=4. Expected results come from a reference
// model that works on whole vectors with plain 64-bit arithmetic.
// Honors NEURON_MAC_SAT_EN the same way the design does.
module tb_neuron_mac;
    import neuron_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 48;
    localparam longint OUT_MAX = 64'sd2147483647;
    localparam longint OUT_MIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inLast;
    logic          outReady;
    logic [DW-1:0] inData;
    logic [DW-1:0] inWeight;
    logic [31:0]   biasV;

    int checks   = 0;
    int failures = 0;

    int vData   [N];
    int vWeight [N];
    bit vLast   [N];

    neuron_mac_if #(.DATA_W(DW)) busA ();
    neuron_mac_if #(.DATA_W(DW)) busB ();

    assign busA.in_valid  = inValid;
    assign busA.in_data   = inData;
    assign busA.in_weight = inWeight;
    assign busA.in_last   = inLast;
    assign busA.bias      = biasV;
    assign busA.out_ready = outReady;
    assign busB.in_valid  = inValid;
    assign busB.in_data   = inData;
    assign busB.in_weight = inWeight;
    assign busB.in_last   = inLast;
    assign busB.bias      = biasV;
    assign busB.out_ready = outReady;

    neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW), .SHIFT(8)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA.slave)
    );

    neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW), .SHIFT(0)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB.slave)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Safety net in case the design stops responding entirely.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint floorDiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Result for a whole vector: floor((dot + bias * 2^sh) / 2^sh), then
    // clamp or wrap into 32 signed bits.
    function automatic longint refX(input longint dot, input int b, input int sh);
        longint scale;
        longint q;
        scale = longint'(1) << sh;
        q = floorDiv(dot + longint'(b) * scale, scale);
`ifdef NEURON_MAC_SAT_EN
        if (q > OUT_MAX) q = OUT_MAX;
        if (q < OUT_MIN) q = OUT_MIN;
`endif
        return longint'(int'(q));
    endfunction

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input int d, input int w, input logic l);
        inValid  = v;
        inData   = DW'(d);
        inWeight = DW'(w);
        inLast   = l;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setVector(input int d, input int w, input int lastAt);
        for (int i = 0; i < N; i++) begin
            vData[i]   = d;
            vWeight[i] = w;
            vLast[i]   = (i == lastAt);
        end
    endtask

    // Streams the current vector (up to its terminating beat), then walks the
    // DRAIN/ROUND/HOLD timeline checking every observable point. Junk beats
    // are offered while the block is busy to show they are never consumed.
    task automatic runVector(input int biasIn, input int holdCycles, input int maxGap);
        int     term;
        longint dot;
        bit     errExp;
        longint expA;
        longint expB;
        term = N - 1;
        for (int i = N - 1; i >= 0; i--) if (vLast[i]) term = i;
        dot = 0;
        for (int i = 0; i <= term; i++) dot += longint'(vData[i]) * longint'(vWeight[i]);
        errExp = ((term + 1) != N) || !vLast[term];
        expA = refX(dot, biasIn, 8);
        expB = refX(dot, biasIn, 0);
        biasV = biasIn;

        for (int i = 0; i <= term; i++) begin
            int gap;
            gap = $urandom_range(0, maxGap);
            repeat (gap) begin
                applyStimulus(1'b0, $urandom, $urandom, 1'b1);
                stepCycle();
            end
            applyStimulus(1'b1, vData[i], vWeight[i], vLast[i]);
            checkOutput("inReadyBeat", busA.in_ready, 1);
            checkOutput("lenErrQuiet", busA.len_err, 0);
            stepCycle();
        end

        applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        checkOutput("lenErrPulse", busA.len_err, errExp);
        checkOutput("inReadyDrain", busA.in_ready, 0);
        checkOutput("outValidDrain", busA.out_valid, 0);
        stepCycle();
        checkOutput("lenErrClear", busA.len_err, 0);
        checkOutput("outValidRound", busA.out_valid, 0);
        stepCycle();
        checkOutput("outValidHold", busA.out_valid, 1);
        checkOutput("outXShift8", $signed(busA.out_x), expA);
        checkOutput("outXShift0", $signed(busB.out_x), expB);
        checkOutput("inReadyHold", busA.in_ready, 0);

        repeat (holdCycles) begin
            applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            stepCycle();
            checkOutput("outValidStall", busA.out_valid, 1);
            checkOutput("outXStable", $signed(busA.out_x), expA);
            checkOutput("inReadyStall", busA.in_ready, 0);
        end

        outReady = 1'b1;
        stepCycle();
        outReady = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0);
        checkOutput("outValidDone", busA.out_valid, 0);
        checkOutput("inReadyBack", busA.in_ready, 1);
    endtask

    initial begin
        reset    = 1'b1;
        outReady = 1'b0;
        biasV    = '0;
        applyStimulus(1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetOutValid", busA.out_valid, 0);
        checkOutput("resetOutX", $signed(busA.out_x), 0);
        checkOutput("resetLenErr", busA.len_err, 0);
        checkOutput("resetInReady", busA.in_ready, 0);
        reset = 1'b0;
        #1;
        checkOutput("releaseInReady", busA.in_ready, 1);

        $display("[TB] directed vectors");
        setVector(256, 256, 3);
        runVector(0, 0, 0);
        runVector(100, 0, 0);
        setVector(-256, 512, 3);
        runVector(0, 5, 0);
        setVector(-1, 1, 0);
        runVector(0, 1, 0);
        setVector(256, 256, 1);
        runVector(0, 0, 0);
        setVector(256, 256, -1);
        runVector(0, 0, 0);
        setVector(32767, 32767, 3);
        runVector(32'h7FFF_FFFF, 0, 0);
        setVector(-32768, 32767, 3);
        runVector(int'(32'h8000_0000), 0, 0);

        $display("[TB] reset mid-vector");
        setVector(1000, 1000, -1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, vData[i], vWeight[i], 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, 0, 0, 1'b0);
        reset = 1'b1;
        stepCycle();
        checkOutput("midResetInReady", busA.in_ready, 0);
        checkOutput("midResetOutValid", busA.out_valid, 0);
        checkOutput("midResetLenErr", busA.len_err, 0);
        reset = 1'b0;
        #1;
        checkOutput("midReleaseInReady", busA.in_ready, 1);
        setVector(256, 256, 3);
        runVector(0, 0, 0);

        $display("[TB] random vectors");
        for (int v = 0; v < 40; v++) begin
            for (int i = 0; i < N; i++) begin
                vData[i]   = int'($urandom_range(0, 65535)) - 32768;
                vWeight[i] = int'($urandom_range(0, 65535)) - 32768;
                vLast[i]   = ($urandom_range(0, 3) == 0);
            end
            runVector(int'($urandom), $urandom_range(0, 3), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

- Streaming multiply-accumulate neuron that produces the 32-bit signed pre-activation value `x` consumed by the downstream sigmoid stage.
- Accepts one (data, weight) pair per handshake beat and accumulates a full-precision dot product over one input vector.
- Adds a bias, rescales by an arithmetic right shift, then holds the result with a valid/ready handshake.
- The sigmoid stage samples `x` every cycle, so `out_x` stays stable while `out_valid` is high.

## Interface
- `N_INPUTS`, 16: beats per vector; the beat counter width is clog2(N_INPUTS).
- `DATA_W`, 16: signed width of `in_data` and `in_weight`.
- `ACC_W`, 48: accumulator width; must be ≥ 2·DATA_W + clog2(N_INPUTS) + 1.
- `SHIFT`, 8: arithmetic right shift applied after bias add.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_data` in DATA_W: signed activation.
- `in_weight` in DATA_W: signed weight.
- `in_last` in 1: final beat of the vector.
- `bias` in 32: signed; sampled in state ROUND.
- `out_valid` out 1: `out_x` holds a result.
- `out_ready` in 1: consumer accepts the result.
- `out_x` out 32: signed pre-activation, feeds sigmoid `x`.
- `len_err` out 1: one-cycle pulse on a vector-length violation.

## Operation
- FSM states: ACCUM → DRAIN → ROUND → HOLD → ACCUM.
- ACCUM:
  - `in_ready` = 1.
  - Each accepted beat (`in_valid` && `in_ready`) registers the product `prod_r` = `in_data` × `in_weight` (2·DATA_W, signed) and increments the beat counter.
  - Each valid `prod_r` is sign-extended to ACC_W and added to `acc` one cycle later.
- End of vector, on whichever comes first:
  - a beat with `in_last`, or
  - the N_INPUTS-th beat.
  - In either case the FSM goes to DRAIN.
- Length errors:
  - `in_last` on beat count ≠ N_INPUTS → `len_err` pulses; the vector still ends and the result is emitted.
  - N_INPUTS beats accepted without `in_last` → `len_err` pulses; the N-th beat is treated as last.
- DRAIN: the final `prod_r` is added into `acc`.
- ROUND: `out_x` ← resize((`acc` + (sext(`bias`) << SHIFT)) >>> SHIFT), computed at ACC_W+1 bits. The shift floors toward −∞, so −1 >>> 8 = −1. `out_valid` ← 1.
- HOLD:
  - `in_ready` = 0; `out_x` and `out_valid` are stable until `out_ready`.
  - On the handshake: `out_valid` ← 0, `acc` and counter clear, state → ACCUM.
- Reset:
  - Reset values: `out_valid` = 0, `out_x` = 0, `len_err` = 0, `acc` = 0, counter = 0, `prod_r` valid = 0, state = ACCUM.
  - `in_ready` = 0 while `reset` is high.
  - Reset mid-vector discards all partial sums.
- Beats with `in_valid` high outside ACCUM are not accepted; the source must hold them.

## Timing
- Last beat accepted on edge k:
  - edge k+1: `acc` includes the last product.
  - edge k+2: `out_x` is valid and `out_valid` = 1.
- `in_ready` goes low the cycle after edge k.
- `in_ready` goes high in the cycle after the output handshake edge.
- Throughput: N + 3 cycles per vector at minimum, one vector in flight.
- `len_err` is asserted for exactly the cycle after the terminating beat's edge.
- `bias` must be stable during the ROUND cycle.

## Configuration
- `NEURON_MAC_SAT_EN` defined: the ROUND result saturates to [−2^31, 2^31−1].
- Not defined: the low 32 bits are taken (two's-complement wrap).

## Structure
- Shared package `neuron_pkg`:
  - state enum (ACCUM, DRAIN, ROUND, HOLD)
  - default DATA_W/ACC_W/SHIFT constants
  - OUT_W = 32
- Sub-module `mac_round_sat`: combinational bias-add, shift and saturate/wrap, honouring `NEURON_MAC_SAT_EN`. Instantiated once.

## Test plan
All cases use N_INPUTS=4, SHIFT=8 unless stated.
- Basic sum: 4 beats, data=256, weight=256, bias=0 → `out_x`=1024. Same vector with bias=100 → `out_x`=1124. `out_valid` appears 2 edges after the last beat.
- Negative and floor: 4 beats, data=−256, weight=512 → `out_x`=−2048. One beat data=−1, weight=1 with `in_last` → `out_x`=−1 and `len_err` pulses.
- Backpressure: `out_ready` low for 5 cycles → `out_x` stable, `in_ready`=0 and `in_valid` beats not consumed. Release → next vector accepted the cycle after the handshake.
- Early last: `in_last` on beat 2 with data=weight=256 → `out_x`=512 and a one-cycle `len_err`.
- Saturation: SHIFT=0, 4 beats of 32767×32767, bias=0x7FFFFFFF. With `NEURON_MAC_SAT_EN` → 0x7FFFFFFF. Without → 0x7FFC0003.
- Reset mid-vector: 2 beats accepted, `reset` for 1 cycle, then a clean 4-beat vector of 256×256 → `out_x`=1024, no `len_err`.
